// File: rtl/exec_pkg.sv
// Shared constants and enums for the execute stage.
// The iterative multiply is built only when EXEC_MUL_EN is defined.
package exec_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 6;
  localparam int MUL_CYCLES = 32;  // one iteration per operand bit
  localparam int CNT_W      = $clog2(MUL_CYCLES);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_unit_mul_iter.sv
// Shift-add multiplier datapath: one partial product per clock while run_i.
// acc_next_o already contains the current iteration, so the caller can
// capture the finished product on the same edge done_o is high.
// Instantiated only when EXEC_MUL_EN is defined.
module mul_iter
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;

  assign acc_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o     = run_i && (cnt_q == LAST);

  // Load operands on start, then shift and accumulate one bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (run_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next_o;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus optional iterative multiply, writing
// results back to the register file through a one-cycle we pulse.
// Define EXEC_MUL_EN to build the multiplier; otherwise op 110 is illegal.
module exec_unit
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic [ADDR_W-1:0] dst,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              busy,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] alu_res;
  logic              accept;

  assign in_ready = (state_q != MUL);
  assign accept   = in_valid && in_ready;
  assign we       = (state_q == WB);
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign err      = err_q;

`ifdef EXEC_MUL_EN
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_acc_next;
  logic [ADDR_W-1:0] dst_q, dst_d;

  assign busy = (state_q == MUL);

  mul_iter u_mul (
    .clk        (clk),
    .rst        (rst),
    .start_i    (mul_start),
    .run_i      (state_q == MUL),
    .a_i        (opa),
    .b_i        (opb),
    .acc_next_o (mul_acc_next),
    .done_o     (mul_done)
  );
`else
  assign busy = 1'b0;
`endif

  // Single-cycle ALU result for the incoming operands.
  always_comb begin
    alu_res = '0;
    case (op_e'(op))
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: alu_res = '0;
    endcase
  end

  // Next-state and output-register logic; wa/wd only change with a fresh result.
  always_comb begin
    state_d = IDLE;
    wa_d    = wa_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
`ifdef EXEC_MUL_EN
    mul_start = 1'b0;
    dst_d     = dst_q;
`endif
    case (state_q)
`ifdef EXEC_MUL_EN
      MUL: begin
        state_d = MUL;
        if (mul_done) begin
          state_d = WB;
          wa_d    = dst_q;
          wd_d    = mul_acc_next;
        end
      end
`endif
      default: begin
        if (accept) begin
          case (op_e'(op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
              state_d = WB;
              wa_d    = dst;
              wd_d    = alu_res;
            end
`ifdef EXEC_MUL_EN
            OP_MUL: begin
              state_d   = MUL;
              mul_start = 1'b1;
              dst_d     = dst;
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wa_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

`ifdef EXEC_MUL_EN
  // Destination held across the multiply so wa is untouched until write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dst_q <= '0;
    else     dst_q <= dst_d;
  end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [5:0]  dst = '0;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  exec_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .dst      (dst),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] d);
    in_valid = 1'b1;
    op = o; opa = a; opb = b; dst = d;
  endtask

  // Issue one op, advance past its accept edge, drop valid.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] d);
    drive(o, a, b, d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
    checks++; if (wa !== 6'd0) begin errors++; $display("FAIL reset_wa got %0d want 0", wa); end
    checks++; if (wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", wd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    issue(3'b000, 32'h5, 32'h3, 6'd7);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL add_we got %b want 1", we); end
    checks++; if (wa !== 6'd7) begin errors++; $display("FAIL add_wa got %0d want 7", wa); end
    checks++; if (wd !== 32'h8) begin errors++; $display("FAIL add_wd got %h want 00000008", wd); end
    step();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL add_we_drop got %b want 0", we); end
    checks++; if (wd !== 32'h8 || wa !== 6'd7) begin errors++; $display("FAIL add_hold got wa=%0d wd=%h want 7/00000008", wa, wd); end
  endtask

  task automatic test_sub_slt();
    issue(3'b001, 32'h0, 32'h1, 6'd4);
    checks++; if (we !== 1'b1 || wd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap got we=%b wd=%h want 1/ffffffff", we, wd); end
    issue(3'b101, 32'hFFFF_FFFF, 32'h1, 6'd5);
    checks++; if (we !== 1'b1 || wd !== 32'h1 || wa !== 6'd5) begin errors++; $display("FAIL slt_true got we=%b wa=%0d wd=%h want 1/5/00000001", we, wa, wd); end
    issue(3'b101, 32'h1, 32'hFFFF_FFFF, 6'd0);
    checks++; if (we !== 1'b1 || wd !== 32'h0 || wa !== 6'd0) begin errors++; $display("FAIL slt_false got we=%b wa=%0d wd=%h want 1/0/00000000", we, wa, wd); end
    issue(3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd6);
    checks++; if (wd !== 32'h0F00_0F00) begin errors++; $display("FAIL and got %h want 0f000f00", wd); end
    issue(3'b011, 32'hFF00_0000, 32'h0000_00FF, 6'd6);
    checks++; if (wd !== 32'hFF00_00FF) begin errors++; $display("FAIL or got %h want ff0000ff", wd); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(3'b000, 32'h2, 32'h3, 6'd1);
    step();
    drive(3'b100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 6'd2);
    checks++; if (we !== 1'b1 || wa !== 6'd1 || wd !== 32'h5) begin errors++; $display("FAIL b2b_first got we=%b wa=%0d wd=%h want 1/1/00000005", we, wa, wd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (we !== 1'b1 || wa !== 6'd2 || wd !== 32'h0F0F_0F0F) begin errors++; $display("FAIL b2b_second got we=%b wa=%0d wd=%h want 1/2/0f0f0f0f", we, wa, wd); end
    step();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", we); end
  endtask

  // Illegal opcode: err pulse, no write, wa/wd untouched (last write was 2/0f0f0f0f).
  task automatic test_illegal(input logic [2:0] o, input string nm);
    issue(o, 32'h1234, 32'h5678, 6'd33);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL %s_err got %b want 1", nm, err); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL %s_we got %b want 0", nm, we); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", nm, in_ready); end
    checks++; if (wa !== 6'd2 || wd !== 32'h0F0F_0F0F) begin errors++; $display("FAIL %s_hold got wa=%0d wd=%h want 2/0f0f0f0f", nm, wa, wd); end
    step();
    checks++; if (err !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL %s_pulse got err=%b we=%b want 0/0", nm, err, we); end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    int busy_cycles = 0;
    int bad = 0;
    issue(3'b110, 32'h0001_0000, 32'h0001_0001, 6'd9);
    drive(3'b000, 32'h10, 32'h20, 6'd3);
    for (int i = 0; i < 32; i++) begin
      if (busy === 1'b1 && in_ready === 1'b0) busy_cycles++;
      if (we !== 1'b0) bad++;
      step();
    end
    checks++; if (busy_cycles != 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", busy_cycles); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_early_we got %0d want 0", bad); end
    checks++; if (we !== 1'b1 || wa !== 6'd9 || wd !== 32'h0001_0000) begin errors++; $display("FAIL mul_wb got we=%b wa=%0d wd=%h want 1/9/00010000", we, wa, wd); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mul_wb_ready got rdy=%b busy=%b want 1/0", in_ready, busy); end
    step();
    in_valid = 1'b0;
    checks++; if (we !== 1'b1 || wa !== 6'd3 || wd !== 32'h30) begin errors++; $display("FAIL mul_second got we=%b wa=%0d wd=%h want 1/3/00000030", we, wa, wd); end
    step();
    issue(3'b110, 32'hFFFF_FFFF, 32'h3, 6'd10);
    repeat (32) step();
    checks++; if (we !== 1'b1 || wd !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_wrap got we=%b wd=%h want 1/fffffffd", we, wd); end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int wes = 0;
    issue(3'b110, 32'h7, 32'h9, 6'd11);
    repeat (9) step();
    rst = 1'b1;
    #1;
    checks++; if (we !== 1'b0 || wa !== 6'd0 || wd !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul got we=%b wa=%0d wd=%h busy=%b rdy=%b want 0/0/0/0/1", we, wa, wd, busy, in_ready); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (we !== 1'b0) wes++;
      step();
    end
    checks++; if (wes != 0) begin errors++; $display("FAIL rst_mul_nowrite got %0d want 0", wes); end
    issue(3'b000, 32'h11, 32'h22, 6'd12);
    checks++; if (we !== 1'b1 || wa !== 6'd12 || wd !== 32'h33) begin errors++; $display("FAIL rst_mul_add got we=%b wa=%0d wd=%h want 1/12/00000033", we, wa, wd); end
    step();
  endtask
`endif

  task automatic test_reset_in_wb();
    int wes = 0;
    issue(3'b000, 32'h1, 32'h1, 6'd13);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (we !== 1'b0 || wd !== 32'd0) begin errors++; $display("FAIL rst_wb got we=%b wd=%h want 0/0", we, wd); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (we !== 1'b0) wes++;
      step();
    end
    checks++; if (wes != 0) begin errors++; $display("FAIL rst_wb_nowrite got %0d want 0", wes); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_back_to_back();
    test_illegal(3'b111, "rsvd");
`ifdef EXEC_MUL_EN
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
`else
    test_illegal(3'b110, "mul_off");
`endif
    test_reset_in_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
